// File: rtl/cla_pkg.sv
// Shared sizing constants for the 32-bit carry-lookahead adder.
// Combinational constants only; no latency or backpressure of its own.
package cla_pkg;
  localparam int WIDTH   = 32;
  localparam int GROUP   = 4;
  localparam int NGROUPS = WIDTH / GROUP;
endpackage

// File: rtl/cla_4bit.sv
// 4-bit lookahead group: flat carry equations, sum bits, group G/P.
// Purely combinational; no latency, no backpressure.
module cla_4bit
  import cla_pkg::*;
(
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] b,
  input  logic             cin,
  output logic [GROUP-1:0] s,
  output logic             G,
  output logic             P
);

  logic [GROUP-1:0] g;
  logic [GROUP-1:0] p;
  logic [GROUP-1:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // Every carry is a two-level sum of products of g, p and cin.
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);

  assign G = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
           | (p[3] & p[2] & p[1] & g[0]);
  assign P = &p;

  assign s = p ^ c;

endmodule

// File: rtl/cla_lcu_8.sv
// Second-level lookahead: group carry-ins and carry-out from group G/P.
// Purely combinational; no latency, no backpressure.
module cla_lcu_8
  import cla_pkg::*;
(
  input  logic [NGROUPS-1:0] gg,
  input  logic [NGROUPS-1:0] pg,
  input  logic               cin,
  output logic [NGROUPS:0]   c
);

  logic term;

  // c[k] = OR over j<k of (gg[j] & pg[j+1..k-1]), plus the all-propagate cin term.
  always_comb begin
    c    = '0;
    term = 1'b0;
    c[0] = cin;
    for (int k = 1; k <= NGROUPS; k++) begin
      term = cin;
      for (int m = 0; m < k; m++) begin
        term = term & pg[m];
      end
      c[k] = term;
      for (int j = 0; j < k; j++) begin
        term = gg[j];
        for (int m = j + 1; m < k; m++) begin
          term = term & pg[m];
        end
        c[k] = c[k] | term;
      end
    end
  end

endmodule

// File: rtl/cla_32bit.sv
// 32-bit unsigned carry-lookahead adder with registered {Cout, Sum}.
// Latency 1 cycle; no handshake or backpressure, accepts an add every cycle.
module cla_32bit
  import cla_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout
);

  logic [NGROUPS-1:0] grp_g;
  logic [NGROUPS-1:0] grp_p;
  logic [NGROUPS:0]   grp_c;
  logic [WIDTH-1:0]   sum_c;

  for (genvar i = 0; i < NGROUPS; i++) begin : g_grp
    cla_4bit u_grp (
      .a   (A[i*GROUP +: GROUP]),
      .b   (B[i*GROUP +: GROUP]),
      .cin (grp_c[i]),
      .s   (sum_c[i*GROUP +: GROUP]),
      .G   (grp_g[i]),
      .P   (grp_p[i])
    );
  end

  // No carry-in into the adder, so the lookahead unit sees a constant 0.
  cla_lcu_8 u_lcu (
    .gg  (grp_g),
    .pg  (grp_p),
    .cin (1'b0),
    .c   (grp_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      Sum  <= '0;
      Cout <= 1'b0;
    end else begin
      Sum  <= sum_c;
      Cout <= grp_c[NGROUPS];
    end
  end

endmodule

// File: tb/tb_cla_32bit.sv
// Bench for cla_32bit: directed vector table, reset/hold sequences, random adds vs a 33-bit model.
module tb_cla_32bit;

  logic        clk;
  logic        rst;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] Sum;
  logic        Cout;

  int nvec;
  int nerr;

  cla_32bit dut (
    .clk  (clk),
    .rst  (rst),
    .A    (A),
    .B    (B),
    .Sum  (Sum),
    .Cout (Cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] s;
    logic        c;
    string       name;
  } vec_t;

  vec_t tbl[9];

  task automatic check(input string name, input logic [31:0] exp_s, input logic exp_c);
    nvec++;
    if (Sum !== exp_s || Cout !== exp_c) begin
      nerr++;
      $display("FAIL %s: got Cout=%0d Sum=0x%08h, want Cout=%0d Sum=0x%08h",
               name, Cout, Sum, exp_c, exp_s);
    end
  endtask

  // Drive operands away from the active edge, then sample just after it.
  task automatic apply(input logic [31:0] a, input logic [31:0] b, input logic r);
    @(negedge clk);
    A   = a;
    B   = b;
    rst = r;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic [32:0] ref_r;

    nvec = 0;
    nerr = 0;
    rst  = 1'b1;
    A    = 32'd0;
    B    = 32'd0;

    tbl[0] = '{32'd10,        32'd20,        32'd30,         1'b0, "add_10_20"};
    tbl[1] = '{32'd123,       32'd456,       32'd579,        1'b0, "add_123_456"};
    tbl[2] = '{32'd987654321, 32'd123456789, 32'd1111111110, 1'b0, "add_big"};
    tbl[3] = '{32'h0000FFFF,  32'd1,         32'h00010000,   1'b0, "chain_ffff_1"};
    tbl[4] = '{32'hFFFFFFFF,  32'd1,         32'h00000000,   1'b1, "wrap_ffffffff_1"};
    tbl[5] = '{32'hFFFFFFFF,  32'hFFFFFFFF,  32'hFFFFFFFE,   1'b1, "wrap_all_ones"};
    tbl[6] = '{32'd1,         32'd2,         32'd3,          1'b0, "stream_1_2"};
    tbl[7] = '{32'd3,         32'd4,         32'd7,          1'b0, "stream_3_4"};
    tbl[8] = '{32'h80000000,  32'h80000000,  32'h00000000,   1'b1, "stream_msb_msb"};

    // Reset holds outputs at zero even with live operands.
    apply(32'd3, 32'd4, 1'b1);
    check("reset_state", 32'd0, 1'b0);
    apply(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
    check("reset_ignores_ops", 32'd0, 1'b0);

    // Consecutive edges, so rows 6..8 also cover back-to-back streaming.
    for (int i = 0; i < 9; i++) begin
      apply(tbl[i].a, tbl[i].b, 1'b0);
      check(tbl[i].name, tbl[i].s, tbl[i].c);
    end

    // Mid-stream reset with a nonzero result present.
    apply(32'd100, 32'd200, 1'b0);
    check("pre_reset_300", 32'd300, 1'b0);
    apply(32'hFFFFFFFF, 32'd2, 1'b1);
    check("midstream_reset", 32'd0, 1'b0);
    apply(32'd5, 32'd7, 1'b0);
    check("post_reset_5_7", 32'd12, 1'b0);

    // Held inputs hold the result; changing one operand updates next edge.
    apply(32'd5, 32'd7, 1'b0);
    check("hold_1", 32'd12, 1'b0);
    apply(32'd5, 32'd7, 1'b0);
    check("hold_2", 32'd12, 1'b0);
    apply(32'd5, 32'hFFFFFFFB, 1'b0);
    check("change_b_only", 32'd0, 1'b1);
    apply(32'h12345678, 32'hFFFFFFFB, 1'b0);
    check("change_a_only", 32'h12345673, 1'b1);

    // Random adds, biased towards long carry chains.
    for (int i = 0; i < 300; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0: rb = $urandom;
        1: rb = ~ra;
        2: rb = ~ra + 32'd1;
        default: rb = 32'd1 << $urandom_range(0, 31);
      endcase
      ref_r = model(ra, rb);
      apply(ra, rb, 1'b0);
      check("random", ref_r[31:0], ref_r[32]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/cla_32bit.md
Name: cla_32bit

Overview:
- 32-bit unsigned carry-lookahead adder with a registered result. Computes Sum = A + B and carry-out Cout.
- Used as a general-purpose datapath adder wherever a fast 32-bit add with a single pipeline register is needed.
- No carry-in. No overflow flag; the signed interpretation is the consumer's job.

Parameters:
- None. Width is fixed by package constants: WIDTH = 32, GROUP = 4.

Ports:
- clk   input   1    system clock; all state updates on rising edge
- rst   input   1    synchronous reset, active-high
- A     input   32   addend, unsigned
- B     input   32   addend, unsigned
- Sum   output  32   registered low 32 bits of A + B
- Cout  output  1    registered carry out of bit 31

Interface (already decided): one clock (clk); reset rst is synchronous and active-high.

Behaviour:
- Combinational core: per-bit generate g[i] = A[i] & B[i] and propagate p[i] = A[i] ^ B[i].
- 4-bit groups:
  - Each group forms internal carries by lookahead equations, with no ripple inside the group.
  - Each group exports group generate G and group propagate P.
- Second-level lookahead unit: computes the 8 group carry-ins from the G/P values with carry-in 0. Group 0 carry-in is 0.
- Sum bit: s[i] = p[i] ^ c[i]. Cout = carry out of group 7.
- Required result: {Cout, Sum} equals the 33-bit zero-extended value A + B, exactly, for all inputs.
- Register stage:
  - On each rising clk with rst = 0, Sum and Cout load the combinational result of the A and B present at that edge.
  - Latency is 1 cycle. Throughput is one add per cycle. There is no handshake; the adder is always valid after the first post-reset edge.
- Reset:
  - rst = 1 at a rising edge forces Sum = 0 and Cout = 0.
  - Reset takes priority over the new result, including a reset asserted mid-stream.
  - The first valid result appears on the first edge after rst deasserts.
- Wrap-around: a sum ≥ 2^32 sets Cout = 1 and Sum = sum mod 2^32.
- Inputs held constant: outputs hold constant. Changing only one operand updates the result on the next edge.
- No internal state other than the 33 output flops.

Decomposition:
- Shared package cla_pkg holds:
  - WIDTH = 32
  - GROUP = 4
  - NGROUPS = WIDTH / GROUP = 8
- Sub-module cla_4bit (natural, instantiated 8×):
  - Inputs: a[3:0], b[3:0], cin.
  - Outputs: s[3:0], G, P.
- Second-level lookahead equations: inline generate block in cla_32bit, or a small lookahead module cla_lcu_8.
- Output register lives in cla_32bit only.

Test Plan:
- Basic adds, each pair held one cycle with rst = 0; results checked one cycle after the operands:
  - A = 10, B = 20 → Sum = 30, Cout = 0.
  - A = 123, B = 456 → Sum = 579, Cout = 0.
  - A = 987654321, B = 123456789 → Sum = 1111111110, Cout = 0.
- Carry propagation and wrap:
  - A = 0x0000FFFF, B = 1 → Sum = 0x00010000, Cout = 0 (full group-boundary carry chain).
  - A = 0xFFFFFFFF, B = 1 → Sum = 0, Cout = 1.
  - A = 0xFFFFFFFF, B = 0xFFFFFFFF → Sum = 0xFFFFFFFE, Cout = 1.
- Reset:
  - Output nonzero, then rst = 1 for one edge → Sum = 0, Cout = 0 at that edge.
  - After rst drops with A = 5, B = 7 → Sum = 12 one edge later.
- Latency and streaming: back-to-back operand pairs (1,2), (3,4), (0x80000000, 0x80000000) on consecutive edges → Sum/Cout sequence (3,0), (7,0), (0,1), each exactly one cycle after its inputs.
